// File: rtl/panel_sequencer.sv
// panel_sequencer
//   Turns front-panel switch actions into CPU run/stop/single-step control
//   and panel-initiated memory cycles (examine / deposit), and drives the
//   panel address/data LEDs.
//
// Ports
//   clk, reset           system clock, synchronous active-high reset
//   addr_sw[15:0]        address switches; [7:0] are also the deposit data
//   ctl_sw[8:0]          control switches (0 RUN, 1 STOP, 2 STEP, 3 EXAMINE,
//                        4 EXAMINE_NEXT, 5 DEPOSIT, 6 DEPOSIT_NEXT, 7 RESET)
//   cpu_addr, cpu_data   CPU buses shown on the LEDs while the CPU is clocked
//   cpu_m1               CPU opcode-fetch indicator, used for single step
//   cpu_ce, cpu_reset    CPU clock enable and reset
//   bus_panel            panel owns the memory port (CPU not clocked)
//   mem_req/we/addr/wdata, mem_rdata, mem_ack
//                        panel memory port. Handshake: mem_req rises with
//                        mem_we/mem_addr/mem_wdata already stable and holds
//                        them all unchanged until the cycle mem_ack is seen
//                        high; mem_req drops on that same edge. mem_rdata is
//                        only sampled in the mem_ack cycle.
//   addrLEDs, dataLEDs   registered LED values
//   wait_led             CPU stopped
//   mem_err              sticky memory timeout, cleared by the next accepted action
//   dbg_state[2:0]       current FSM state
module panel_sequencer #(
  parameter int RESET_CYCLES = 16,
  parameter int MEM_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr_sw,
  input  logic [8:0]  ctl_sw,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data,
  input  logic        cpu_m1,
  output logic        cpu_ce,
  output logic        cpu_reset,
  output logic        bus_panel,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic [15:0] addrLEDs,
  output logic [7:0]  dataLEDs,
  output logic        wait_led,
  output logic        mem_err,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    ST_STOPPED   = 3'd0,
    ST_RUNNING   = 3'd1,
    ST_STEP_RUN  = 3'd2,
    ST_STEP_WAIT = 3'd3,
    ST_MEM_REQ   = 3'd4,
    ST_RST       = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [8:0]  prev_q, prev_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] pa_q, pa_d;
  logic [7:0]  pd_q, pd_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [15:0] addr_led_q, addr_led_d;
  logic [7:0]  data_led_q, data_led_d;

  logic [8:0]  act;
  logic [7:0]  sel;
  logic        cpu_active;

  always_comb begin
    act = ctl_sw & ~prev_q;

    // One-hot pick of the single winning edge; all others this cycle are lost.
    sel = '0;
    if      (act[7]) sel[7] = 1'b1;
    else if (act[1]) sel[1] = 1'b1;
    else if (act[0]) sel[0] = 1'b1;
    else if (act[2]) sel[2] = 1'b1;
    else if (act[3]) sel[3] = 1'b1;
    else if (act[4]) sel[4] = 1'b1;
    else if (act[5]) sel[5] = 1'b1;
    else if (act[6]) sel[6] = 1'b1;

    cpu_active = (state_q == ST_RUNNING) || (state_q == ST_STEP_RUN) ||
                 (state_q == ST_STEP_WAIT);

    state_d = state_q;
    prev_d  = ctl_sw;
    cnt_d   = cnt_q;
    pa_d    = pa_q;
    pd_d    = pd_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    err_d   = err_q;

    if (sel[7]) begin
      // RESET wins from any state and restarts the hold count.
      state_d = ST_RST;
      cnt_d   = '0;
      pa_d    = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        ST_STOPPED: begin
          if (sel[0]) begin
            state_d = ST_RUNNING;
            err_d   = 1'b0;
          end else if (sel[2]) begin
            state_d = ST_STEP_RUN;
            err_d   = 1'b0;
          end else if (|sel[6:3]) begin
            state_d = ST_MEM_REQ;
            cnt_d   = '0;
            err_d   = 1'b0;
            we_d    = sel[5] | sel[6];
            wdata_d = addr_sw[7:0];
            if (sel[3])               pa_d = addr_sw;
            else if (sel[4] | sel[6]) pa_d = pa_q + 16'd1;
          end
        end
        ST_RUNNING: begin
          if (sel[1]) begin
            state_d = ST_STOPPED;
            err_d   = 1'b0;
          end
        end
        ST_STEP_RUN: begin
          if (sel[1]) begin
            state_d = ST_STOPPED;
            err_d   = 1'b0;
          end else if (!cpu_m1) begin
            state_d = ST_STEP_WAIT;
          end
        end
        ST_STEP_WAIT: begin
          if (sel[1]) begin
            state_d = ST_STOPPED;
            err_d   = 1'b0;
          end else if (cpu_m1) begin
            // Next fetch has started: park and remember where we are.
            state_d = ST_STOPPED;
            pa_d    = cpu_addr;
          end
        end
        ST_MEM_REQ: begin
          if (mem_ack) begin
            state_d = ST_STOPPED;
            pd_d    = we_q ? wdata_q : mem_rdata;
          end else if (cnt_q == 16'(MEM_TIMEOUT - 1)) begin
            state_d = ST_STOPPED;
            err_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        ST_RST: begin
          if (cnt_q == 16'(RESET_CYCLES - 1)) state_d = ST_STOPPED;
          else                                cnt_d   = cnt_q + 16'd1;
        end
        default: state_d = ST_STOPPED;
      endcase
    end

    addr_led_d = cpu_active ? cpu_addr : pa_q;
    data_led_d = cpu_active ? cpu_data : pd_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_STOPPED;
      prev_q     <= ctl_sw;  // no action fires for switches already held
      cnt_q      <= '0;
      pa_q       <= '0;
      pd_q       <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      addr_led_q <= '0;
      data_led_q <= '0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      cnt_q      <= cnt_d;
      pa_q       <= pa_d;
      pd_q       <= pd_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      err_q      <= err_d;
      addr_led_q <= addr_led_d;
      data_led_q <= data_led_d;
    end
  end

  assign cpu_reset = (state_q == ST_RST);
  assign cpu_ce    = cpu_active | cpu_reset;
  assign bus_panel = ~cpu_ce;
  assign wait_led  = ~cpu_ce;
  assign mem_req   = (state_q == ST_MEM_REQ);
  assign mem_we    = we_q & mem_req;
  assign mem_addr  = pa_q;
  assign mem_wdata = wdata_q;
  assign addrLEDs  = addr_led_q;
  assign dataLEDs  = data_led_q;
  assign mem_err   = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_panel_sequencer.sv
module tb_panel_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addr_sw;
  logic [8:0]  ctl_sw;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        cpu_m1;
  logic        cpu_ce, cpu_reset, bus_panel, mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic [15:0] addrLEDs;
  logic [7:0]  dataLEDs;
  logic        wait_led, mem_err;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  panel_sequencer #(.RESET_CYCLES(16), .MEM_TIMEOUT(255)) dut (
    .clk(clk), .reset(reset), .addr_sw(addr_sw), .ctl_sw(ctl_sw),
    .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_m1(cpu_m1),
    .cpu_ce(cpu_ce), .cpu_reset(cpu_reset), .bus_panel(bus_panel),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .addrLEDs(addrLEDs), .dataLEDs(dataLEDs), .wait_led(wait_led),
    .mem_err(mem_err), .dbg_state(dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise one control switch for a single edge, then release it.
  task automatic pulse(input int idx);
    ctl_sw = '0;
    ctl_sw[idx] = 1'b1;
    tick();
    ctl_sw = '0;
  endtask

  // Memory responder: counts mem_req-high samples and acks so that the
  // ack is seen on the edge ending the ack_cycles-th cycle (0 = never).
  task automatic run_mem(input int ack_cycles, input logic [7:0] rdata,
                         output int high_cnt);
    high_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      if (!mem_req) break;
      high_cnt++;
      if (high_cnt == ack_cycles) begin
        mem_ack   = 1'b1;
        mem_rdata = rdata;
      end
      tick();
      mem_ack = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; ctl_sw = 9'h008; addr_sw = 16'h1234;
    tick(); tick();
    reset = 1'b0;
    tick(); tick(); tick();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    checks++; if (cpu_ce !== 1'b0) begin errors++; $display("FAIL reset_cpu_ce: got %b want 0", cpu_ce); end
    checks++; if (bus_panel !== 1'b1) begin errors++; $display("FAIL reset_bus_panel: got %b want 1", bus_panel); end
    checks++; if (wait_led !== 1'b1) begin errors++; $display("FAIL reset_wait_led: got %b want 1", wait_led); end
    checks++; if (addrLEDs !== 16'h0000) begin errors++; $display("FAIL reset_addrLEDs: got %h want 0000", addrLEDs); end
    checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL reset_cpu_reset: got %b want 0", cpu_reset); end
    checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL reset_mem_err: got %b want 0", mem_err); end
    ctl_sw = '0;
    tick();
  endtask

  task automatic test_examine();
    int n;
    addr_sw = 16'h1234;
    pulse(3);
    checks++; if (mem_addr !== 16'h1234) begin errors++; $display("FAIL exam_addr: got %h want 1234", mem_addr); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL exam_we: got %b want 0", mem_we); end
    run_mem(3, 8'hA5, n);
    checks++; if (n !== 3) begin errors++; $display("FAIL exam_req_len: got %0d want 3", n); end
    tick();
    checks++; if (addrLEDs !== 16'h1234) begin errors++; $display("FAIL exam_addrLEDs: got %h want 1234", addrLEDs); end
    checks++; if (dataLEDs !== 8'hA5) begin errors++; $display("FAIL exam_dataLEDs: got %h want a5", dataLEDs); end
  endtask

  task automatic test_examine_next();
    int n;
    pulse(4);
    checks++; if (mem_addr !== 16'h1235) begin errors++; $display("FAIL examnext_addr: got %h want 1235", mem_addr); end
    run_mem(1, 8'h5A, n);
    tick();
    checks++; if (dataLEDs !== 8'h5A) begin errors++; $display("FAIL examnext_data: got %h want 5a", dataLEDs); end
  endtask

  task automatic test_deposit_next_wrap();
    int n;
    addr_sw = 16'hFFFF;
    pulse(3);
    run_mem(1, 8'h11, n);
    addr_sw = 16'h003C;
    tick();
    pulse(6);
    checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL depnext_addr: got %h want 0000", mem_addr); end
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL depnext_we: got %b want 1", mem_we); end
    checks++; if (mem_wdata !== 8'h3C) begin errors++; $display("FAIL depnext_wdata: got %h want 3c", mem_wdata); end
    run_mem(2, 8'h00, n);
    checks++; if (n !== 2) begin errors++; $display("FAIL depnext_req_len: got %0d want 2", n); end
    tick();
    checks++; if (dataLEDs !== 8'h3C) begin errors++; $display("FAIL depnext_dataLEDs: got %h want 3c", dataLEDs); end
  endtask

  task automatic test_deposit();
    int n;
    addr_sw = 16'h5577;
    pulse(5);
    checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL dep_addr: got %h want 0000", mem_addr); end
    checks++; if (mem_wdata !== 8'h77) begin errors++; $display("FAIL dep_wdata: got %h want 77", mem_wdata); end
    run_mem(1, 8'hEE, n);
    tick();
    checks++; if (dataLEDs !== 8'h77) begin errors++; $display("FAIL dep_dataLEDs: got %h want 77", dataLEDs); end
  endtask

  task automatic test_timeout();
    int n;
    addr_sw = 16'h4000;
    pulse(3);
    run_mem(0, 8'h00, n);
    checks++; if (n !== 255) begin errors++; $display("FAIL tmo_req_len: got %0d want 255", n); end
    checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL tmo_err_set: got %b want 1", mem_err); end
    tick();
    checks++; if (dataLEDs !== 8'h77) begin errors++; $display("FAIL tmo_pd_kept: got %h want 77", dataLEDs); end
    pulse(3);
    checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL tmo_err_clear: got %b want 0", mem_err); end
    run_mem(1, 8'h99, n);
    tick();
  endtask

  task automatic test_run_stop();
    cpu_addr = 16'hBEEF; cpu_data = 8'h42;
    checks++; if (cpu_ce !== 1'b0) begin errors++; $display("FAIL run_pre_ce: got %b want 0", cpu_ce); end
    pulse(0);
    checks++; if (cpu_ce !== 1'b1) begin errors++; $display("FAIL run_ce: got %b want 1", cpu_ce); end
    checks++; if (bus_panel !== 1'b0) begin errors++; $display("FAIL run_bus_panel: got %b want 0", bus_panel); end
    checks++; if (wait_led !== 1'b0) begin errors++; $display("FAIL run_wait_led: got %b want 0", wait_led); end
    tick();
    checks++; if (addrLEDs !== 16'hBEEF) begin errors++; $display("FAIL run_addrLEDs: got %h want beef", addrLEDs); end
    checks++; if (dataLEDs !== 8'h42) begin errors++; $display("FAIL run_dataLEDs: got %h want 42", dataLEDs); end
    pulse(3);  // ignored while running
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL run_exam_ignored: got %b want 0", mem_req); end
    cpu_addr = 16'h1111;
    tick();
    checks++; if (addrLEDs !== 16'h1111) begin errors++; $display("FAIL run_track: got %h want 1111", addrLEDs); end
    checks++; if (cpu_ce !== 1'b1) begin errors++; $display("FAIL run_before_stop: got %b want 1", cpu_ce); end
    pulse(1);
    checks++; if (cpu_ce !== 1'b0) begin errors++; $display("FAIL stop_ce: got %b want 0", cpu_ce); end
    checks++; if (bus_panel !== 1'b1) begin errors++; $display("FAIL stop_bus_panel: got %b want 1", bus_panel); end
    tick();
  endtask

  task automatic test_step();
    cpu_m1 = 1'b1; cpu_addr = 16'h2000;
    pulse(2);
    checks++; if (cpu_ce !== 1'b1) begin errors++; $display("FAIL step_ce_start: got %b want 1", cpu_ce); end
    tick();
    cpu_m1 = 1'b0;
    repeat (5) tick();
    checks++; if (cpu_ce !== 1'b1) begin errors++; $display("FAIL step_ce_m1low: got %b want 1", cpu_ce); end
    cpu_addr = 16'h2001;
    cpu_m1 = 1'b1;
    checks++; if (cpu_ce !== 1'b1) begin errors++; $display("FAIL step_ce_m1rise: got %b want 1", cpu_ce); end
    tick();
    checks++; if (cpu_ce !== 1'b0) begin errors++; $display("FAIL step_ce_drop: got %b want 0", cpu_ce); end
    cpu_addr = 16'h7777;
    tick();
    checks++; if (addrLEDs !== 16'h2001) begin errors++; $display("FAIL step_pa: got %h want 2001", addrLEDs); end
  endtask

  task automatic test_reset_priority();
    int n;
    ctl_sw = 9'h081;  // RESET and RUN together
    tick();
    ctl_sw = '0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (!cpu_reset) break;
      n++;
      checks++; if (cpu_ce !== 1'b1) begin errors++; $display("FAIL rst_ce: got %b want 1", cpu_ce); end
      tick();
    end
    checks++; if (n !== 16) begin errors++; $display("FAIL rst_len: got %0d want 16", n); end
    checks++; if (cpu_ce !== 1'b0) begin errors++; $display("FAIL rst_after_ce: got %b want 0", cpu_ce); end
    tick();
    checks++; if (addrLEDs !== 16'h0000) begin errors++; $display("FAIL rst_pa_clear: got %h want 0000", addrLEDs); end
  endtask

  task automatic test_reset_abort_retrigger();
    int n;
    addr_sw = 16'h0F0F;
    pulse(3);
    tick();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL abort_pre_req: got %b want 1", mem_req); end
    pulse(7);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL abort_req: got %b want 0", mem_req); end
    repeat (4) tick();
    ctl_sw = 9'h080;
    tick();
    ctl_sw = '0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (!cpu_reset) break;
      n++;
      tick();
    end
    checks++; if (n !== 16) begin errors++; $display("FAIL retrigger_len: got %0d want 16", n); end
  endtask

  // Sequence + final report
  initial begin
    reset = 1'b1; addr_sw = '0; ctl_sw = '0; cpu_addr = '0; cpu_data = '0;
    cpu_m1 = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
    test_reset();
    test_examine();
    test_examine_next();
    test_deposit_next_wrap();
    test_deposit();
    test_timeout();
    test_run_stop();
    test_step();
    test_reset_priority();
    test_reset_abort_retrigger();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
